cond_exec_stage: RTL and testbench
==================================

// Module: cond_exec_stage
// PURPOSE
//  Execute-stage condition logic plus EX->MEM pipeline register, directly downstream of the ALU.
//  Holds the architectural NZCV flags register and evaluates each instruction's condition field
//  against the flags. Gates register, memory and PC writes for failed conditions.
//  Updates flags from ALUFlags {N,Z,C,V} = bits [3:0]. Registers ALU result and control into M.
// PARAMETERS
//  BITS     32  datapath width (ALUResultE, WriteDataE)
//  RA_BITS  4   destination register address width
// PORTS
//  clk         in   1        clock, rising edge
//  reset       in   1        asynchronous, active-high; clears all state
//  StallM      in   1        1 = hold M register and flags register
//  FlushM      in   1        1 = insert bubble into M; overrides StallM
//  CondE       in   4        condition field of instruction in E
//  FlagWriteE  in   2        [1] = write N,Z; [0] = write C,V
//  ALUFlags    in   4        {N,Z,C,V} from ALU, same cycle
//  ALUResultE  in   BITS     ALU result
//  WriteDataE  in   BITS     store data
//  WA3E        in   RA_BITS  destination register
//  RegWriteE   in   1        register write request
//  MemWriteE   in   1        memory write request
//  MemtoRegE   in   1        result-select request
//  PCSrcE      in   1        write-to-PC request
//  BranchE     in   1        branch instruction
//  CondExE     out  1        combinational: condition passed
//  BranchTakenE out 1        combinational: BranchE & CondExE
//  FlagsQ      out  4        current flags register {N,Z,C,V}
//  ALUResultM, WriteDataM  out BITS; WA3M out RA_BITS; RegWriteM, MemWriteM, MemtoRegM, PCSrcM out 1
// BEHAVIOUR
//  - Reset (async): FlagsQ = 4'b0000; every M output = 0; takes effect immediately, not at the clock edge.
//  - Condition codes are evaluated against FlagsQ, not ALUFlags.
//    0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V;
//    8 HI C&~Z; 9 LS ~C|Z; A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE Z|(N!=V); E AL 1; F 1.
//  - Flag update at the rising edge requires all of: CondExE=1, StallM=0, FlushM=0.
//    FlagWriteE[1] loads N,Z from ALUFlags[3:2]; FlagWriteE[0] loads C,V from ALUFlags[1:0].
//    Bits not selected hold.
//  - M register, latency 1 cycle. When StallM=0 and FlushM=0:
//    - data fields (ALUResultM, WriteDataM, WA3M) load unconditionally;
//    - RegWriteM/MemWriteM/PCSrcM load the request ANDed with CondExE;
//    - MemtoRegM loads MemtoRegE unconditionally.
//  - FlushM=1: all M outputs and control bits <= 0; flags unchanged. Flush takes priority over stall.
//  - StallM=1 and FlushM=0: all M outputs and FlagsQ hold.
//  - Back-to-back: a flag-setting instruction followed by a conditional instruction sees the new
//    flags in the next cycle. There is no same-cycle flag bypass.
//  - A failed condition produces a bubble-equivalent M (no write enables) but data still passes through.
// STRUCTURE
//  - Package cond_pkg:
//    - cond_e enum, 4-bit: EQ..AL, NV;
//    - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
//    - flags_t packed struct {n,z,c,v}.
//  - Sub-module cond_check: combinational (CondE, FlagsQ) -> CondExE.
//  - Top level holds the flags register and the M pipeline register, each in its own always_ff.
// TESTING
//  - Reset: assert reset mid-run with M populated -> all M outputs 0 and FlagsQ=0000 before the next edge.
//  - FlagWriteE=11, ALUFlags=0100 (Z), CondE=E -> next cycle FlagsQ=0100;
//    then CondE=0 (EQ), RegWriteE=1 -> RegWriteM=1; with CondE=1 (NE) -> RegWriteM=0.
//  - Partial write: FlagsQ=1010, FlagWriteE=01, ALUFlags=0101 -> FlagsQ=1001.
//  - Failed condition: FlagsQ=0000, CondE=0 (EQ), FlagWriteE=11, MemWriteE=1, ALUResultE=0x1234
//    -> FlagsQ stays 0000, MemWriteM=0, ALUResultM=0x1234.
//  - StallM=1 for 2 cycles with changing inputs -> M outputs and FlagsQ frozen;
//    StallM=1 with FlushM=1 -> M control cleared.
//  - Sweep all 16 CondE values across all 16 FlagsQ values -> CondExE matches the table;
//    BranchE=1 -> BranchTakenE equals CondExE.

Source files
------------

// File: rtl/cond_exec_stage_pkg.sv
// rtl/cond_exec_stage_pkg.sv - condition codes, flag indices and flag struct for the execute stage
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/cond_exec_stage_if.sv
// rtl/cond_exec_stage_if.sv - E-stage inputs and M-stage outputs of the condition/EX->MEM stage
interface cond_exec_stage_if #(
    parameter int BITS    = 32,
    parameter int RA_BITS = 4
);
    logic                StallM;
    logic                FlushM;
    logic [3:0]          CondE;
    logic [1:0]          FlagWriteE;
    logic [3:0]          ALUFlags;
    logic [BITS-1:0]     ALUResultE;
    logic [BITS-1:0]     WriteDataE;
    logic [RA_BITS-1:0]  WA3E;
    logic                RegWriteE;
    logic                MemWriteE;
    logic                MemtoRegE;
    logic                PCSrcE;
    logic                BranchE;

    logic                CondExE;
    logic                BranchTakenE;
    logic [3:0]          FlagsQ;
    logic [BITS-1:0]     ALUResultM;
    logic [BITS-1:0]     WriteDataM;
    logic [RA_BITS-1:0]  WA3M;
    logic                RegWriteM;
    logic                MemWriteM;
    logic                MemtoRegM;
    logic                PCSrcM;

    modport master (
        output StallM, FlushM, CondE, FlagWriteE, ALUFlags, ALUResultE, WriteDataE, WA3E,
               RegWriteE, MemWriteE, MemtoRegE, PCSrcE, BranchE,
        input  CondExE, BranchTakenE, FlagsQ, ALUResultM, WriteDataM, WA3M,
               RegWriteM, MemWriteM, MemtoRegM, PCSrcM
    );

    modport slave (
        input  StallM, FlushM, CondE, FlagWriteE, ALUFlags, ALUResultE, WriteDataE, WA3E,
               RegWriteE, MemWriteE, MemtoRegE, PCSrcE, BranchE,
        output CondExE, BranchTakenE, FlagsQ, ALUResultM, WriteDataM, WA3M,
               RegWriteM, MemWriteM, MemtoRegM, PCSrcM
    );
endinterface

// File: rtl/cond_exec_stage_check.sv
// rtl/cond_exec_stage_check.sv - combinational condition-code evaluation against the flags register
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  flags_t     flags,
    output logic       cond_ex
);

    always_comb begin
        cond_ex = 1'b1;
        case (cond_e'(cond))
            EQ: cond_ex = flags.z;
            NE: cond_ex = ~flags.z;
            CS: cond_ex = flags.c;
            CC: cond_ex = ~flags.c;
            MI: cond_ex = flags.n;
            PL: cond_ex = ~flags.n;
            VS: cond_ex = flags.v;
            VC: cond_ex = ~flags.v;
            HI: cond_ex = flags.c & ~flags.z;
            LS: cond_ex = ~flags.c | flags.z;
            GE: cond_ex = (flags.n == flags.v);
            LT: cond_ex = (flags.n != flags.v);
            GT: cond_ex = ~flags.z & (flags.n == flags.v);
            LE: cond_ex = flags.z | (flags.n != flags.v);
            AL: cond_ex = 1'b1;
            NV: cond_ex = 1'b1;
            default: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_exec_stage.sv
// rtl/cond_exec_stage.sv - NZCV flags register, condition gating and EX->MEM pipeline register
module cond_exec_stage
    import cond_pkg::*;
#(
    parameter int BITS    = 32,
    parameter int RA_BITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    cond_exec_stage_if.slave   bus
);

    flags_t              flags_q;
    logic                cond_ex;
    logic                advance;

    logic [BITS-1:0]     alu_result_q;
    logic [BITS-1:0]     write_data_q;
    logic [RA_BITS-1:0]  wa3_q;
    logic                reg_write_q;
    logic                mem_write_q;
    logic                mem_to_reg_q;
    logic                pc_src_q;

    // Conditions see the committed flags only; there is no bypass from ALUFlags.
    cond_check u_check (
        .cond    (bus.CondE),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    assign advance = ~bus.StallM & ~bus.FlushM;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
        end else if (advance && cond_ex) begin
            if (bus.FlagWriteE[1]) begin
                flags_q.n <= bus.ALUFlags[FLAG_N];
                flags_q.z <= bus.ALUFlags[FLAG_Z];
            end
            if (bus.FlagWriteE[0]) begin
                flags_q.c <= bus.ALUFlags[FLAG_C];
                flags_q.v <= bus.ALUFlags[FLAG_V];
            end
        end
    end

    // Flush wins over stall; a failed condition still forwards data but drops write enables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || bus.FlushM) begin
            alu_result_q <= '0;
            write_data_q <= '0;
            wa3_q        <= '0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            pc_src_q     <= 1'b0;
        end else if (!bus.StallM) begin
            alu_result_q <= bus.ALUResultE;
            write_data_q <= bus.WriteDataE;
            wa3_q        <= bus.WA3E;
            reg_write_q  <= bus.RegWriteE & cond_ex;
            mem_write_q  <= bus.MemWriteE & cond_ex;
            mem_to_reg_q <= bus.MemtoRegE;
            pc_src_q     <= bus.PCSrcE & cond_ex;
        end
    end

    assign bus.CondExE      = cond_ex;
    assign bus.BranchTakenE = bus.BranchE & cond_ex;
    assign bus.FlagsQ       = flags_q;
    assign bus.ALUResultM   = alu_result_q;
    assign bus.WriteDataM   = write_data_q;
    assign bus.WA3M         = wa3_q;
    assign bus.RegWriteM    = reg_write_q;
    assign bus.MemWriteM    = mem_write_q;
    assign bus.MemtoRegM    = mem_to_reg_q;
    assign bus.PCSrcM       = pc_src_q;

endmodule

// File: tb/tb_cond_exec_stage.sv
// tb/tb_cond_exec_stage.sv - directed self-checking bench for cond_exec_stage
module tb_cond_exec_stage;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    cond_exec_stage_if #(.BITS(32), .RA_BITS(4)) bus ();

    cond_exec_stage #(.BITS(32), .RA_BITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, b;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cf;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cf & ~z;
            3'd5: b = (n == v);
            3'd6: b = ~z & (n == v);
            default: b = 1'b1;
        endcase
        if (c == 4'hF) return 1'b1;
        return b ^ c[0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.StallM = 0; bus.FlushM = 0; bus.CondE = 4'hE; bus.FlagWriteE = 2'b00;
        bus.ALUFlags = 4'h0; bus.ALUResultE = '0; bus.WriteDataE = '0; bus.WA3E = '0;
        bus.RegWriteE = 0; bus.MemWriteE = 0; bus.MemtoRegE = 0; bus.PCSrcE = 0; bus.BranchE = 0;
    endtask

    task automatic load_flags(input logic [3:0] f);
        bus.CondE = 4'hE; bus.FlagWriteE = 2'b11; bus.ALUFlags = f;
        step();
        bus.FlagWriteE = 2'b00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        #2;
        checks++; if (bus.FlagsQ !== 4'h0) begin failures++; $display("FAIL reset_flags got=%h exp=0", bus.FlagsQ); end
        checks++; if ({bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM, bus.PCSrcM} !== 4'h0) begin failures++; $display("FAIL reset_ctrl got=%b exp=0000", {bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM, bus.PCSrcM}); end
        checks++; if ({bus.ALUResultM, bus.WriteDataM, bus.WA3M} !== 68'h0) begin failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", bus.ALUResultM, bus.WriteDataM, bus.WA3M); end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_flag_eq();
        load_flags(4'b0000);
        bus.CondE = 4'hE; bus.FlagWriteE = 2'b11; bus.ALUFlags = 4'b0100;
        step();
        checks++; if (bus.FlagsQ !== 4'b0100) begin failures++; $display("FAIL eq_flags got=%b exp=0100", bus.FlagsQ); end
        bus.FlagWriteE = 2'b00; bus.CondE = 4'h0; bus.RegWriteE = 1;
        #1;
        checks++; if (bus.CondExE !== 1'b1) begin failures++; $display("FAIL eq_condex got=%b exp=1", bus.CondExE); end
        step();
        checks++; if (bus.RegWriteM !== 1'b1) begin failures++; $display("FAIL eq_regwrite got=%b exp=1", bus.RegWriteM); end
        bus.CondE = 4'h1;
        step();
        checks++; if (bus.RegWriteM !== 1'b0) begin failures++; $display("FAIL ne_regwrite got=%b exp=0", bus.RegWriteM); end
        clear_inputs();
    endtask

    task automatic test_partial_write();
        load_flags(4'b1010);
        checks++; if (bus.FlagsQ !== 4'b1010) begin failures++; $display("FAIL partial_setup got=%b exp=1010", bus.FlagsQ); end
        bus.FlagWriteE = 2'b01; bus.ALUFlags = 4'b0101;
        step();
        checks++; if (bus.FlagsQ !== 4'b1001) begin failures++; $display("FAIL partial_cv got=%b exp=1001", bus.FlagsQ); end
        bus.FlagWriteE = 2'b10; bus.ALUFlags = 4'b0110;
        step();
        checks++; if (bus.FlagsQ !== 4'b0101) begin failures++; $display("FAIL partial_nz got=%b exp=0101", bus.FlagsQ); end
        clear_inputs();
    endtask

    task automatic test_failed_cond();
        load_flags(4'b0000);
        bus.CondE = 4'h0; bus.FlagWriteE = 2'b11; bus.ALUFlags = 4'b1111;
        bus.MemWriteE = 1; bus.RegWriteE = 1; bus.PCSrcE = 1; bus.MemtoRegE = 1;
        bus.ALUResultE = 32'h0000_1234; bus.WriteDataE = 32'hCAFE_0001; bus.WA3E = 4'd7;
        step();
        checks++; if (bus.FlagsQ !== 4'b0000) begin failures++; $display("FAIL failed_flags got=%b exp=0000", bus.FlagsQ); end
        checks++; if ({bus.RegWriteM, bus.MemWriteM, bus.PCSrcM} !== 3'b000) begin failures++; $display("FAIL failed_enables got=%b exp=000", {bus.RegWriteM, bus.MemWriteM, bus.PCSrcM}); end
        checks++; if (bus.MemtoRegM !== 1'b1) begin failures++; $display("FAIL failed_memtoreg got=%b exp=1", bus.MemtoRegM); end
        checks++; if (bus.ALUResultM !== 32'h0000_1234) begin failures++; $display("FAIL failed_result got=%h exp=00001234", bus.ALUResultM); end
        checks++; if ({bus.WriteDataM, bus.WA3M} !== {32'hCAFE_0001, 4'd7}) begin failures++; $display("FAIL failed_data got=%h/%h exp=cafe0001/7", bus.WriteDataM, bus.WA3M); end
        clear_inputs();
    endtask

    task automatic test_stall_flush();
        load_flags(4'b0000);
        bus.CondE = 4'hE; bus.FlagWriteE = 2'b10; bus.ALUFlags = 4'b1000;
        bus.RegWriteE = 1; bus.MemWriteE = 1; bus.MemtoRegE = 1; bus.PCSrcE = 1;
        bus.ALUResultE = 32'hAAAA_5555; bus.WriteDataE = 32'h1111_2222; bus.WA3E = 4'd5;
        step();
        bus.StallM = 1;
        for (int i = 0; i < 2; i++) begin
            bus.ALUResultE = 32'hDEAD_0000 + i; bus.WriteDataE = 32'h0BAD_0000 + i; bus.WA3E = 4'd9 + 4'(i);
            bus.FlagWriteE = 2'b11; bus.ALUFlags = 4'b0111; bus.RegWriteE = 0; bus.MemWriteE = 0;
            bus.MemtoRegE = 0; bus.PCSrcE = 0;
            step();
            checks++; if (bus.FlagsQ !== 4'b1000) begin failures++; $display("FAIL stall_flags cyc=%0d got=%b exp=1000", i, bus.FlagsQ); end
            checks++; if ({bus.ALUResultM, bus.WriteDataM, bus.WA3M} !== {32'hAAAA_5555, 32'h1111_2222, 4'd5}) begin failures++; $display("FAIL stall_data cyc=%0d got=%h/%h/%h", i, bus.ALUResultM, bus.WriteDataM, bus.WA3M); end
            checks++; if ({bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM, bus.PCSrcM} !== 4'b1111) begin failures++; $display("FAIL stall_ctrl cyc=%0d got=%b exp=1111", i, {bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM, bus.PCSrcM}); end
        end
        bus.FlushM = 1;
        step();
        checks++; if ({bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM, bus.PCSrcM} !== 4'b0000) begin failures++; $display("FAIL flush_ctrl got=%b exp=0000", {bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM, bus.PCSrcM}); end
        checks++; if ({bus.ALUResultM, bus.WriteDataM, bus.WA3M} !== 68'h0) begin failures++; $display("FAIL flush_data got=%h/%h/%h exp=0", bus.ALUResultM, bus.WriteDataM, bus.WA3M); end
        checks++; if (bus.FlagsQ !== 4'b1000) begin failures++; $display("FAIL flush_flags got=%b exp=1000", bus.FlagsQ); end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        load_flags(4'b0000);
        bus.CondE = 4'h0; bus.FlagWriteE = 2'b11; bus.ALUFlags = 4'b0100;
        #1;
        checks++; if (bus.CondExE !== 1'b0) begin failures++; $display("FAIL b2b_no_bypass got=%b exp=0", bus.CondExE); end
        step();
        checks++; if (bus.FlagsQ !== 4'b0000) begin failures++; $display("FAIL b2b_blocked got=%b exp=0000", bus.FlagsQ); end
        bus.CondE = 4'hE;
        step();
        bus.CondE = 4'h0; bus.FlagWriteE = 2'b00; bus.RegWriteE = 1;
        #1;
        checks++; if (bus.CondExE !== 1'b1) begin failures++; $display("FAIL b2b_condex got=%b exp=1", bus.CondExE); end
        step();
        checks++; if (bus.RegWriteM !== 1'b1) begin failures++; $display("FAIL b2b_regwrite got=%b exp=1", bus.RegWriteM); end
        clear_inputs();
    endtask

    task automatic test_cond_sweep();
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            checks++; if (bus.FlagsQ !== 4'(f)) begin failures++; $display("FAIL sweep_flags got=%b exp=%b", bus.FlagsQ, 4'(f)); end
            bus.BranchE = 1;
            for (int c = 0; c < 16; c++) begin
                bus.CondE = 4'(c);
                #1;
                checks++; if (bus.CondExE !== exp_cond(4'(c), 4'(f))) begin failures++; $display("FAIL sweep_cond c=%h f=%b got=%b exp=%b", c, f, bus.CondExE, exp_cond(4'(c), 4'(f))); end
                checks++; if (bus.BranchTakenE !== exp_cond(4'(c), 4'(f))) begin failures++; $display("FAIL sweep_branch c=%h f=%b got=%b exp=%b", c, f, bus.BranchTakenE, exp_cond(4'(c), 4'(f))); end
            end
            clear_inputs();
        end
    endtask

    task automatic test_reset_midrun();
        load_flags(4'b1111);
        bus.CondE = 4'hE; bus.RegWriteE = 1; bus.MemWriteE = 1; bus.PCSrcE = 1; bus.MemtoRegE = 1;
        bus.ALUResultE = 32'h5A5A_5A5A; bus.WriteDataE = 32'h0F0F_0F0F; bus.WA3E = 4'd3;
        step();
        checks++; if (bus.RegWriteM !== 1'b1 || bus.ALUResultM !== 32'h5A5A_5A5A) begin failures++; $display("FAIL midrun_populate got=%b/%h exp=1/5a5a5a5a", bus.RegWriteM, bus.ALUResultM); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.FlagsQ !== 4'h0) begin failures++; $display("FAIL midrun_flags got=%b exp=0000", bus.FlagsQ); end
        checks++; if ({bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM, bus.PCSrcM} !== 4'h0) begin failures++; $display("FAIL midrun_ctrl got=%b exp=0000", {bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM, bus.PCSrcM}); end
        checks++; if ({bus.ALUResultM, bus.WriteDataM, bus.WA3M} !== 68'h0) begin failures++; $display("FAIL midrun_data got=%h/%h/%h exp=0", bus.ALUResultM, bus.WriteDataM, bus.WA3M); end
        step();
        reset = 1'b0;
        clear_inputs();
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_flag_eq();
        test_partial_write();
        test_failed_cond();
        test_stall_flush();
        test_back_to_back();
        test_cond_sweep();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
